// File: rtl/vga_img_disp_if.sv
// Bus bundle for vga_img_disp: the two ROM read ports plus the video output.
// master = the display core, slave = the ROM / video sink side.
interface vga_img_disp_if #(
   parameter int AW = 16,
   parameter int DW = 8
);
   logic [AW-1:0] addra;
   logic [AW-1:0] addrb;
   logic [DW-1:0] qa;
   logic [DW-1:0] qb;
   logic          hs;
   logic          vs;
   logic          de;
   logic [DW-1:0] rgb;
   logic [1:0]    mode;
   logic          frame_start;

   modport master (
      output addra, addrb, hs, vs, de, rgb, mode, frame_start,
      input  qa, qb
   );

   modport slave (
      input  addra, addrb, hs, vs, de, rgb, mode, frame_start,
      output qa, qb
   );
endinterface

// File: rtl/vga_img_disp.sv
// Parametrised VGA timing generator and two-image compositor.
// The counters feed an address stage, the ROM adds ROM_LAT cycles, and a final
// register produces rgb; sync/de/frame_start ride a matching delay line.
//
// Mode FSM:
//   state    | meaning
//   M_A      | image A (port A) centred in the active area
//   M_B      | image B (port B) centred in the active area
//   M_BOUNCE | image A, origin moves one pixel diagonally per frame
//   M_BARS   | eight vertical colour bars
module vga_img_disp #(
   parameter int             H_ACTIVE = 640,
   parameter int             H_FP     = 16,
   parameter int             H_SYNC   = 96,
   parameter int             H_BP     = 48,
   parameter int             V_ACTIVE = 480,
   parameter int             V_FP     = 10,
   parameter int             V_SYNC   = 2,
   parameter int             V_BP     = 33,
   parameter int             SYNC_POL = 0,
   parameter int             IMG_W    = 200,
   parameter int             IMG_H    = 200,
   parameter int             AW       = 16,
   parameter int             DW       = 8,
   parameter int             ROM_LAT  = 1,
   parameter logic [DW-1:0]  BG_COLOR = '0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           key_pulse,
   vga_img_disp_if.master bus
);
   localparam int H_TOT    = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOT    = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int HW       = $clog2(H_TOT);
   localparam int VW       = $clog2(V_TOT);
   localparam int HS_START = H_ACTIVE + H_FP;
   localparam int HS_END   = HS_START + H_SYNC;
   localparam int VS_START = V_ACTIVE + V_FP;
   localparam int VS_END   = VS_START + V_SYNC;
   localparam int BAR_W    = H_ACTIVE / 8;

   localparam logic [HW-1:0] H_LAST = HW'(H_TOT - 1);
   localparam logic [VW-1:0] V_LAST = VW'(V_TOT - 1);
   localparam logic [HW-1:0] X_MAX  = HW'(H_ACTIVE - IMG_W);
   localparam logic [VW-1:0] Y_MAX  = VW'(V_ACTIVE - IMG_H);
   localparam logic [HW-1:0] X_C    = HW'((H_ACTIVE - IMG_W) / 2);
   localparam logic [VW-1:0] Y_C    = VW'((V_ACTIVE - IMG_H) / 2);
   localparam logic          SP     = (SYNC_POL != 0);
   localparam logic          SP_N   = ~SP;

   localparam logic [7:0] BAR_TBL [0:7] =
      '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};

   typedef enum logic [1:0] {M_A = 2'd0, M_B = 2'd1, M_BOUNCE = 2'd2, M_BARS = 2'd3} mode_t;

   // Pixel source chosen at the address stage and resolved after the ROM.
   localparam logic [1:0] SRC_NONE = 2'd0;
   localparam logic [1:0] SRC_QA   = 2'd1;
   localparam logic [1:0] SRC_QB   = 2'd2;
   localparam logic [1:0] SRC_COL  = 2'd3;

   typedef struct packed {
      logic          hs;
      logic          vs;
      logic          de;
      logic          fs;
      logic [1:0]    src;
      logic [DW-1:0] col;
   } ctl_t;

   localparam ctl_t CTL_RST = {SP_N, SP_N, 1'b0, 1'b0, SRC_NONE, {DW{1'b0}}};

   logic [HW-1:0] h_cnt;
   logic [VW-1:0] v_cnt;
   logic [HW-1:0] x0, x_step;
   logic [VW-1:0] y0, y_step;
   logic          dx_pos, dy_pos;
   mode_t         mode_q;
   logic [1:0]    pending_q;
   int            hx, vx, x0i, y0i;
   logic          active, in_win, frame_end;
   logic [AW-1:0] addr_nxt;
   logic [DW-1:0] bar_col;
   ctl_t          ctl_nxt;
   ctl_t          pipe [0:ROM_LAT];

   assign hx        = int'(h_cnt);
   assign vx        = int'(v_cnt);
   assign x0i       = int'(x0);
   assign y0i       = int'(y0);
   assign active    = (hx < H_ACTIVE) && (vx < V_ACTIVE);
   assign in_win    = (hx >= x0i) && (hx < x0i + IMG_W) && (vx >= y0i) && (vx < y0i + IMG_H);
   assign addr_nxt  = in_win ? AW'((vx - y0i) * IMG_W + (hx - x0i)) : '0;
   assign frame_end = (h_cnt == H_LAST) && (v_cnt == V_LAST);
   assign x_step    = dx_pos ? x0 + 1'b1 : x0 - 1'b1;
   assign y_step    = dy_pos ? y0 + 1'b1 : y0 - 1'b1;
   assign bus.mode  = mode_q;

   // Raster counters: h wraps every line, v advances on each h wrap.
   always_ff @(posedge clk) begin
      if (rst) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (h_cnt == H_LAST) begin
         h_cnt <= '0;
         v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
      end else begin
         h_cnt <= h_cnt + 1'b1;
      end
   end

   // Mode FSM; mode and the bounce origin only change on the last pixel of a frame.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q    <= M_A;
         pending_q <= 2'd0;
         x0        <= X_C;
         y0        <= Y_C;
         dx_pos    <= 1'b1;
         dy_pos    <= 1'b1;
      end else begin
         pending_q <= pending_q + {1'b0, key_pulse};
         if (frame_end) begin
            mode_q <= mode_t'(pending_q);
            if (mode_q == M_BOUNCE && pending_q == 2'd2) begin
               x0 <= x_step;
               y0 <= y_step;
               if (x_step == '0 || x_step == X_MAX) dx_pos <= ~dx_pos;
               if (y_step == '0 || y_step == Y_MAX) dy_pos <= ~dy_pos;
            end else begin
               // Any other frame (including the first in bounce) starts from the centre.
               x0     <= X_C;
               y0     <= Y_C;
               dx_pos <= 1'b1;
               dy_pos <= 1'b1;
            end
         end
      end
   end

   // Colour-bar lookup: the last bar whose left edge is at or before h.
   always_comb begin
      bar_col = DW'(BAR_TBL[0]);
      for (int i = 1; i < 8; i++) begin
         if (hx >= i * BAR_W) bar_col = DW'(BAR_TBL[i]);
      end
   end

   // Per-pixel control word computed alongside the ROM address.
   always_comb begin
      ctl_nxt     = CTL_RST;
      ctl_nxt.hs  = (hx >= HS_START && hx < HS_END) ? SP : SP_N;
      ctl_nxt.vs  = (vx >= VS_START && vx < VS_END) ? SP : SP_N;
      ctl_nxt.de  = active;
      ctl_nxt.fs  = (h_cnt == '0) && (v_cnt == '0);
      ctl_nxt.src = SRC_NONE;
      ctl_nxt.col = '0;
      if (active) begin
         if (mode_q == M_BARS) begin
            ctl_nxt.src = SRC_COL;
            ctl_nxt.col = bar_col;
         end else if (in_win) begin
            ctl_nxt.src = (mode_q == M_B) ? SRC_QB : SRC_QA;
         end else begin
            ctl_nxt.src = SRC_COL;
            ctl_nxt.col = BG_COLOR;
         end
      end
   end

   // Address stage plus the control delay line that tracks the ROM latency.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.addra <= '0;
         bus.addrb <= '0;
         for (int i = 0; i <= ROM_LAT; i++) pipe[i] <= CTL_RST;
      end else begin
         bus.addra <= addr_nxt;
         bus.addrb <= addr_nxt;
         pipe[0]   <= ctl_nxt;
         for (int i = 1; i <= ROM_LAT; i++) pipe[i] <= pipe[i-1];
      end
   end

   // Output register: picks the ROM word or a fixed colour for the aligned pixel.
   always_ff @(posedge clk) begin
      if (rst) begin
         bus.hs          <= SP_N;
         bus.vs          <= SP_N;
         bus.de          <= 1'b0;
         bus.frame_start <= 1'b0;
         bus.rgb         <= '0;
      end else begin
         bus.hs          <= pipe[ROM_LAT].hs;
         bus.vs          <= pipe[ROM_LAT].vs;
         bus.de          <= pipe[ROM_LAT].de;
         bus.frame_start <= pipe[ROM_LAT].fs;
         case (pipe[ROM_LAT].src)
            SRC_QA:  bus.rgb <= bus.qa;
            SRC_QB:  bus.rgb <= bus.qb;
            SRC_COL: bus.rgb <= pipe[ROM_LAT].col;
            default: bus.rgb <= '0;
         endcase
      end
   end
endmodule

// File: tb/tb_vga_img_disp.sv
// Testbench for vga_img_disp with a shrunken raster so many frames fit in a short run.
// A frame-level reference model predicts every output each cycle; a probe table
// and short hand-written sequences cover mode switching, bars, bounce and reset.
module tb_vga_img_disp;
   localparam int HA = 32, HF = 2, HSY = 4, HB = 2;
   localparam int VA = 12, VF = 1, VSY = 2, VB = 1;
   localparam int IW = 8, IH = 4, AW = 16, DW = 8, RL = 1, L = RL + 2;
   localparam int HT = HA + HF + HSY + HB, VT = VA + VF + VSY + VB, FR = HT * VT;
   localparam int XM = HA - IW, YM = VA - IH, CX = XM / 2, CY = YM / 2;
   localparam logic [7:0] BG = 8'h55;
   localparam logic [7:0] BARS [8] = '{8'hFF, 8'hFC, 8'h1F, 8'h1C, 8'hE3, 8'hE0, 8'h03, 8'h00};

   typedef struct {int h; int v; logic hs; logic vs; logic de; logic fs; logic [7:0] rgb;} px_t;
   typedef struct {int md; int h; int v; logic de; logic [7:0] rgb;} vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic key_pulse = 1'b0;
   int vectors = 0;
   int miscompares = 0;

   px_t pipe [L];
   int mh, mv, mpend, mmode, nb;
   logic [AW-1:0] maddr;
   bit chk_on = 1'b0;
   vec_t tbl [22];

   always #5 clk = ~clk;

   vga_img_disp_if #(.AW(AW), .DW(DW)) bus ();

   vga_img_disp #(
      .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSY), .H_BP(HB),
      .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSY), .V_BP(VB),
      .SYNC_POL(0), .IMG_W(IW), .IMG_H(IH), .AW(AW), .DW(DW),
      .ROM_LAT(RL), .BG_COLOR(BG)
   ) dut (
      .clk(clk), .rst(rst), .key_pulse(key_pulse), .bus(bus)
   );

   // ROM model: port A returns addr[7:0], port B its complement, one clock later.
   always @(posedge clk) begin
      bus.qa <= bus.addra[7:0];
      bus.qb <= ~bus.addrb[7:0];
   end

   function automatic bit in_win(int h, int v, int ox, int oy);
      return (h >= ox && h < ox + IW && v >= oy && v < oy + IH);
   endfunction

   // Bounce position after n frames: a triangle wave over [0, m] starting at c, moving up.
   function automatic int tri_pos(int c, int m, int n);
      int p;
      if (m == 0) return 0;
      p = (c + n) % (2 * m);
      return (p <= m) ? p : 2 * m - p;
   endfunction

   function automatic px_t pix(int h, int v, int md, int ox, int oy);
      px_t p;
      logic [7:0] a8;
      p.h   = h;
      p.v   = v;
      p.de  = (h < HA && v < VA);
      p.hs  = (h >= HA + HF && h < HA + HF + HSY) ? 1'b0 : 1'b1;
      p.vs  = (v >= VA + VF && v < VA + VF + VSY) ? 1'b0 : 1'b1;
      p.fs  = (h == 0 && v == 0);
      p.rgb = 8'h00;
      if (p.de) begin
         if (md == 3) p.rgb = BARS[h / (HA / 8)];
         else if (in_win(h, v, ox, oy)) begin
            a8 = 8'((v - oy) * IW + (h - ox));
            p.rgb = (md == 1) ? ~a8 : a8;
         end else p.rgb = BG;
      end
      return p;
   endfunction

   task automatic model_reset();
      for (int i = 0; i < L; i++) pipe[i] = '{-1, -1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
      mh = 0; mv = 0; mpend = 0; mmode = 0; nb = 0; maddr = '0;
   endtask

   task automatic tick();
      px_t np;
      int ox, oy;
      @(posedge clk);
      #1;
      if (rst) begin
         model_reset();
         chk_on = 1'b1;
      end else if (chk_on) begin
         ox = (mmode == 2) ? tri_pos(CX, XM, nb) : CX;
         oy = (mmode == 2) ? tri_pos(CY, YM, nb) : CY;
         np = pix(mh, mv, mmode, ox, oy);
         maddr = in_win(mh, mv, ox, oy) ? AW'((mv - oy) * IW + (mh - ox)) : '0;
         for (int i = L - 1; i > 0; i--) pipe[i] = pipe[i-1];
         pipe[0] = np;
         if (mh == HT - 1 && mv == VT - 1) begin
            nb = (mpend == 2 && mmode == 2) ? nb + 1 : 0;
            mmode = mpend;
         end
         mpend = (mpend + (key_pulse ? 1 : 0)) % 4;
         if (mh == HT - 1) begin
            mh = 0;
            mv = (mv == VT - 1) ? 0 : mv + 1;
         end else mh++;
      end
      if (chk_on) begin
         vectors++;
         if (bus.hs !== pipe[L-1].hs || bus.vs !== pipe[L-1].vs || bus.de !== pipe[L-1].de ||
             bus.rgb !== pipe[L-1].rgb || bus.frame_start !== pipe[L-1].fs ||
             bus.mode !== 2'(mmode) || bus.addra !== maddr || bus.addrb !== maddr) begin
            miscompares++;
            $display("FAIL cycle t=%0t pix(%0d,%0d): got hs=%b vs=%b de=%b rgb=%h fs=%b mode=%0d addra=%0d addrb=%0d, expected hs=%b vs=%b de=%b rgb=%h fs=%b mode=%0d addr=%0d",
                     $time, pipe[L-1].h, pipe[L-1].v, bus.hs, bus.vs, bus.de, bus.rgb, bus.frame_start,
                     bus.mode, bus.addra, bus.addrb, pipe[L-1].hs, pipe[L-1].vs, pipe[L-1].de,
                     pipe[L-1].rgb, pipe[L-1].fs, mmode, maddr);
         end
      end
   endtask

   task automatic chk(string name, int got, int exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0d expected %0d", name, got, exp);
      end
   endtask

   task automatic timeout(string what);
      vectors++;
      miscompares++;
      $display("FAIL timeout %s: got no event within bound, expected one", what);
   endtask

   task automatic run(int n);
      repeat (n) tick();
   endtask

   task automatic pulse();
      key_pulse = 1'b1;
      tick();
      key_pulse = 1'b0;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic run_to_bnd();
      int k = 0;
      while (!(mh == HT - 1 && mv == VT - 1) && k < 2 * FR) begin tick(); k++; end
      if (!(mh == HT - 1 && mv == VT - 1)) timeout("frame boundary");
   endtask

   task automatic run_to(int h, int v);
      int k = 0;
      while (!(mh == h && mv == v) && k < 2 * FR) begin tick(); k++; end
      if (!(mh == h && mv == v)) timeout("counter position");
   endtask

   task automatic wait_pix(int h, int v, output bit ok);
      int k = 0;
      while (!(pipe[L-1].h == h && pipe[L-1].v == v) && k < 2 * FR) begin tick(); k++; end
      ok = (pipe[L-1].h == h && pipe[L-1].v == v);
      if (!ok) timeout("probe pixel");
   endtask

   task automatic set_mode(int target);
      int n, k;
      n = (target - mpend + 4) % 4;
      repeat (n) pulse();
      k = 0;
      while (mmode != target && k < 3 * FR) begin tick(); k++; end
      if (mmode != target) timeout("mode switch");
   endtask

   initial begin
      bit ok;
      // mode, h, v, de, rgb  (window origin (12,4), 8x4 image, qa = addr, qb = ~addr)
      tbl = '{
         '{0,  0,  0, 1'b1, 8'h55}, '{0, 12,  3, 1'b1, 8'h55}, '{0, 12,  4, 1'b1, 8'h00},
         '{0, 11,  5, 1'b1, 8'h55}, '{0, 13,  5, 1'b1, 8'h09}, '{0, 20,  5, 1'b1, 8'h55},
         '{0, 33,  5, 1'b0, 8'h00}, '{0, 19,  7, 1'b1, 8'h1F}, '{0, 12,  8, 1'b1, 8'h55},
         '{0,  5, 13, 1'b0, 8'h00},
         '{1,  5,  5, 1'b1, 8'h55}, '{1, 13,  5, 1'b1, 8'hF6}, '{1, 18,  6, 1'b1, 8'hE9},
         '{3,  0,  0, 1'b1, 8'hFF}, '{3,  4,  0, 1'b1, 8'hFC}, '{3, 32,  0, 1'b0, 8'h00},
         '{3, 24,  1, 1'b1, 8'h03}, '{3,  8,  2, 1'b1, 8'h1F}, '{3, 12,  3, 1'b1, 8'h1C},
         '{3, 16,  5, 1'b1, 8'hE3}, '{3, 20,  5, 1'b1, 8'hE0}, '{3, 31, 11, 1'b1, 8'h00}
      };

      // Reset values
      do_reset();
      chk("reset hs", bus.hs, 1);
      chk("reset vs", bus.vs, 1);
      chk("reset de", bus.de, 0);
      chk("reset rgb", bus.rgb, 0);
      chk("reset frame_start", bus.frame_start, 0);
      chk("reset mode", bus.mode, 0);
      chk("reset addra", bus.addra, 0);

      // Probe table across modes 0, 1 and 3
      for (int i = 0; i < 22; i++) begin
         if (tbl[i].md != mmode) set_mode(tbl[i].md);
         wait_pix(tbl[i].h, tbl[i].v, ok);
         if (ok) begin
            vectors++;
            if (bus.de !== tbl[i].de || bus.rgb !== tbl[i].rgb) begin
               miscompares++;
               $display("FAIL probe %0d mode%0d (%0d,%0d): got de=%b rgb=%h expected de=%b rgb=%h",
                        i, tbl[i].md, tbl[i].h, tbl[i].v, bus.de, bus.rgb, tbl[i].de, tbl[i].rgb);
            end
         end
      end

      // One pulse mid-frame: mode holds until the boundary
      do_reset();
      run_to(0, 6);
      pulse();
      run_to_bnd();
      chk("mid-frame pulse mode before boundary", bus.mode, 0);
      tick();
      chk("mid-frame pulse mode after boundary", bus.mode, 1);
      run(FR);

      // Three pulses in one frame accumulate
      do_reset();
      repeat (3) begin run(100); pulse(); end
      run_to_bnd();
      chk("three pulses mode before boundary", bus.mode, 0);
      tick();
      chk("three pulses mode after boundary", bus.mode, 3);
      run(FR);

      // Pulse on the boundary cycle is deferred one frame
      do_reset();
      run_to_bnd();
      pulse();
      chk("boundary pulse deferred", bus.mode, 0);
      run_to_bnd();
      tick();
      chk("boundary pulse next frame", bus.mode, 1);

      // Bounce: long enough to hit both x limits and several y reflections
      do_reset();
      pulse();
      pulse();
      run_to_bnd();
      tick();
      chk("bounce mode entered", bus.mode, 2);
      run(38 * FR);

      // Mid-line reset in bounce with pending = 3
      pulse();
      run_to(HT / 2, 5);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("mid-line reset hs", bus.hs, 1);
      chk("mid-line reset vs", bus.vs, 1);
      chk("mid-line reset de", bus.de, 0);
      chk("mid-line reset rgb", bus.rgb, 0);
      chk("mid-line reset frame_start", bus.frame_start, 0);
      chk("mid-line reset mode", bus.mode, 0);
      chk("mid-line reset addra", bus.addra, 0);
      run(FR + 10);

      // Random key pulses and occasional resets against the model
      repeat (20 * FR) begin
         key_pulse = ($urandom_range(0, 249) == 0);
         rst = ($urandom_range(0, 7999) == 0);
         tick();
      end
      key_pulse = 1'b0;
      rst = 1'b0;
      run(10);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
